history_rr_arbiter: RTL

//  Packet-granular round-robin arbiter that shares the single packet_history ingress between NUM_PORTS AXI4-Stream requesters.

---
 rtl/history_rr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/history_rr_arbiter.sv
// -----------------------------------------------------------------------------
// history_rr_arbiter
//
// Packet-granular round-robin arbiter that shares the single packet_history
// ingress between NUM_PORTS AXI4-Stream requesters (the per-port RX queues).
// Once a port is granted it keeps the grant until its tlast beat transfers,
// so packets are never interleaved. The data path is a zero-latency
// combinational mux of the granted port. Every packet pays one IDLE cycle
// for arbitration.
//
// Ports
//   axis_aclk       : clock, all logic on the rising edge
//   axis_reset      : synchronous active-high reset. While it is high, all
//                     outputs are also forced to their idle values.
//   s_axis_tdata    : NUM_PORTS x DW, port p at [p*DW +: DW]
//   s_axis_tkeep    : NUM_PORTS x DW/8, port p at [p*DW/8 +: DW/8]
//   s_axis_tuser    : NUM_PORTS x UW, port p at [p*UW +: UW]
//   s_axis_tvalid   : per-port valid
//   s_axis_tlast    : per-port last
//   s_axis_tready   : per-port ready, only the granted port can see a 1
//   m_axis_*        : beat of the granted port; all zero when nothing is granted
//   m_axis_tready   : downstream ready
//   grant_valid     : 1 while a port holds the grant
//   grant_port      : index of the granted (or most recently granted) port
// -----------------------------------------------------------------------------
module history_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4
) (
    input  logic                                         axis_aclk,
    input  logic                                         axis_reset,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS*(C_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                         s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                         s_axis_tlast,
    output logic [NUM_PORTS-1:0]                         s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]               m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                         m_axis_tlast,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]                 grant_port
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [PW-1:0] grant_q;
    logic [PW-1:0] rr_last_q;
    logic [PW-1:0] pick;
    logic          any_req;
    logic          beat_xfer;
    logic          last_xfer;

    // Per-port views of the flattened input buses, so the output mux is a
    // plain array index by grant_q.
    logic [DW-1:0] tdata_a [NUM_PORTS];
    logic [KW-1:0] tkeep_a [NUM_PORTS];
    logic [UW-1:0] tuser_a [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            tdata_a[p] = s_axis_tdata[p*DW +: DW];
            tkeep_a[p] = s_axis_tkeep[p*KW +: KW];
            tuser_a[p] = s_axis_tuser[p*UW +: UW];
        end
    end

    assign any_req   = |s_axis_tvalid;
    assign beat_xfer = (state_q == PASS) && s_axis_tvalid[grant_q] && m_axis_tready;
    assign last_xfer = beat_xfer && s_axis_tlast[grant_q];

    // Round-robin search: first requester after rr_last, wrapping modulo
    // NUM_PORTS, so the previous winner is considered last.
    always_comb begin
        int      idx_i;
        logic    found;
        logic [PW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx_i = (int'(rr_last_q) + i) % NUM_PORTS;
            idx   = PW'(idx_i);
            if (!found && s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // State and grant registers
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_last_q <= PW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_nxt;
            if (state_q == IDLE && any_req) begin
                grant_q <= pick;
            end
            if (last_xfer) begin
                rr_last_q <= grant_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (any_req)   state_nxt = PASS;
            PASS:    if (last_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: pass-through of the granted port only while in PASS and
    // out of reset; everything else idles at zero.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        grant_valid   = 1'b0;
        grant_port    = axis_reset ? '0 : grant_q;
        if (!axis_reset && state_q == PASS) begin
            m_axis_tdata           = tdata_a[grant_q];
            m_axis_tkeep           = tkeep_a[grant_q];
            m_axis_tuser           = tuser_a[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
            grant_valid            = 1'b1;
        end
    end

endmodule
